seg_scan: RTL and testbench



---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_8.sv | 38 +++
 rtl/seg_scan.sv | 123 ++++++++++++
 tb/tb_seg_scan.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scanner.
package seg_pkg;

  // Active-low segment byte {dp,a,b,c,d,e,f,g}.
  typedef logic [7:0] seg_t;

  // All segments dark.
  localparam seg_t SEG_OFF = 8'hFF;

  // Per-slot phase: the blanking gap, then the lit part of the slot.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

endpackage

// File: rtl/seg_8.sv
// Hex nibble to active-low seven-segment decoder with decimal point.
import seg_pkg::*;

module seg_8 (
  input  logic [3:0] data,
  input  logic       dot,
  output logic [7:0] seg
);

  // Active-high glyph in {a,b,c,d,e,f,g} order.
  logic [6:0] glyph;

  // Glyph table lookup, then invert everything for the common-anode pins.
  always_comb begin
    glyph = 7'b0000000;
    case (data)
      4'h0: glyph = 7'b1111110;
      4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;
      4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;
      4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;
      4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1111011;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b0011111;
      4'hC: glyph = 7'b1001110;
      4'hD: glyph = 7'b0111101;
      4'hE: glyph = 7'b1001111;
      4'hF: glyph = 7'b1000111;
      default: glyph = 7'b0000000;
    endcase
    seg = seg_t'({~dot, ~glyph});
  end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed scanner for common-anode seven-segment digits. One decoder is
// shared across all positions; the displayed word is snapshotted once per
// frame and every slot starts with a blanking gap to stop ghosting.
import seg_pkg::*;

module seg_scan #(
  parameter int DIGITS = 6,
  parameter int DIV    = 1000,
  parameter int GAP    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dots,
  input  logic [DIGITS-1:0]     blank,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_start
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GAP_PRE  = CNT_W'(GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  phase_t              phase, phase_next;
  logic [4*DIGITS-1:0] data_snap;
  logic [DIGITS-1:0]   dots_snap;
  logic [DIGITS-1:0]   blank_snap;

  logic [3:0]          nib;
  logic                dot_sel;
  logic                blk_sel;
  logic [DIGITS-1:0]   dig_sel;
  seg_t                dec_seg;

  // Slot counter and digit index; disabling parks the scan at its start.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Phase register; always agrees with (cnt >= GAP).
  always_ff @(posedge clk) begin
    if (!rst_n) phase <= PH_BLANK;
    else        phase <= phase_next;
  end

  // Phase next-state: enter SHOW as cnt reaches GAP, leave at slot wrap.
  always_comb begin
    phase_next = phase;
    case (phase)
      PH_BLANK: if (en && cnt == GAP_PRE)     phase_next = PH_SHOW;
      PH_SHOW:  if (!en || cnt == CNT_LAST)   phase_next = PH_BLANK;
      default:                                phase_next = PH_BLANK;
    endcase
  end

  // Frame snapshot taken at the very start of each enabled frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_snap  <= '0;
      dots_snap  <= '0;
      blank_snap <= '0;
    end else if (en && idx == '0 && cnt == '0) begin
      data_snap  <= data;
      dots_snap  <= dots;
      blank_snap <= blank;
    end
  end

  // Pick the active digit's nibble, dot, blank flag and select pattern.
  always_comb begin
    nib     = 4'h0;
    dot_sel = 1'b0;
    blk_sel = 1'b1;
    dig_sel = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib        = data_snap[4*i +: 4];
        dot_sel    = dots_snap[i];
        blk_sel    = blank_snap[i];
        dig_sel[i] = 1'b0;
      end
    end
  end

  seg_8 u_dec (
    .data (nib),
    .dot  (dot_sel),
    .seg  (dec_seg)
  );

  // Registered pin drive: lit only in SHOW of an enabled, unblanked digit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg         <= SEG_OFF;
      dig         <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= en && idx == '0 && cnt == '0;
      if (en && phase == PH_SHOW && !blk_sel) begin
        seg <= dec_seg;
        dig <= dig_sel;
      end else begin
        seg <= SEG_OFF;
        dig <= '1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with DIGITS=4, DIV=8, GAP=2.
module tb_seg_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int GAP    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] data = 16'h0000;
  logic [3:0]  dots = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_start;

  int n_pass  = 0;
  int n_total = 0;

  logic mon_on = 1'b0;
  int   last_d = -1;
  int   off_run = 0;
  int   cur;

  // Clock.
  always #5 clk = ~clk;

  seg_scan #(.DIGITS(DIGITS), .DIV(DIV), .GAP(GAP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .data        (data),
    .dots        (dots),
    .blank       (blank),
    .seg         (seg),
    .dig         (dig),
    .frame_start (frame_start)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e_seg, input logic [3:0] e_dig,
                         input logic e_fs);
    chk({tag, " seg"}, 16'(seg), 16'(e_seg));
    chk({tag, " dig"}, 16'(dig), 16'(e_dig));
    chk({tag, " frame_start"}, 16'(frame_start), 16'(e_fs));
  endtask

  // Checks output cycles c_from..c_to-1 of the slot for digit d.
  task automatic check_slot(input int d, input logic [7:0] lit_seg, input logic lit,
                            input int c_from, input int c_to);
    logic [3:0] one;
    logic [3:0] e_dig;
    logic [7:0] e_seg;
    logic       on;
    one = 4'b0001;
    for (int c = c_from; c < c_to; c++) begin
      on    = lit && (c >= GAP);
      e_dig = on ? ~(one << d) : 4'hF;
      e_seg = on ? lit_seg : 8'hFF;
      chk_out($sformatf("slot%0d c%0d", d, c), e_seg, e_dig, (d == 0) && (c == 0));
      step();
    end
  endtask

  // Pin invariants: at most one digit low, and a gap before every digit change.
  always @(negedge clk) begin
    if (mon_on) begin
      n_total++;
      assert ($countones(~dig) <= 1) n_pass++;
      else $error("FAIL onehot: observed dig %b expected at most one low bit", dig);
      if (dig != 4'hF) begin
        cur = -1;
        for (int i = 0; i < DIGITS; i++) if (!dig[i]) cur = i;
        if (last_d >= 0 && cur != last_d) begin
          n_total++;
          assert (off_run >= GAP) n_pass++;
          else $error("FAIL gap: observed %0d off cycles expected at least %0d", off_run, GAP);
        end
        last_d  = cur;
        off_run = 0;
      end else begin
        off_run++;
      end
    end
  end

  initial begin
    // Reset held for three edges with scanning requested.
    rst_n = 1'b0;
    en    = 1'b1;
    data  = 16'h3210;
    dots  = 4'h0;
    blank = 4'h0;
    step();
    mon_on = 1'b1;
    step();
    step();
    chk_out("reset", 8'hFF, 4'hF, 1'b0);

    // Frame 1: 0,1,2,3; data changes while digit 1 is lit.
    rst_n = 1'b1;
    step();
    check_slot(0, 8'h81, 1'b1, 0, 8);
    check_slot(1, 8'hCF, 1'b1, 0, 4);
    data = 16'hFFFF;
    check_slot(1, 8'hCF, 1'b1, 4, 8);
    check_slot(2, 8'h92, 1'b1, 0, 8);
    check_slot(3, 8'h86, 1'b1, 0, 8);

    // Frame 2: F everywhere; dot/blank masks arrive mid-frame.
    check_slot(0, 8'hB8, 1'b1, 0, 8);
    check_slot(1, 8'hB8, 1'b1, 0, 8);
    dots  = 4'b0100;
    blank = 4'b0001;
    check_slot(2, 8'hB8, 1'b1, 0, 8);
    check_slot(3, 8'hB8, 1'b1, 0, 8);

    // Frame 3: digit 0 blanked for the whole slot, dot on digit 2.
    check_slot(0, 8'hB8, 1'b0, 0, 8);
    check_slot(1, 8'hB8, 1'b1, 0, 8);
    data  = 16'h3210;
    dots  = 4'h0;
    blank = 4'h0;
    check_slot(2, 8'h38, 1'b1, 0, 8);
    check_slot(3, 8'hB8, 1'b1, 0, 8);

    // Frame 4: enable dropped in the middle of digit 2.
    check_slot(0, 8'h81, 1'b1, 0, 8);
    check_slot(1, 8'hCF, 1'b1, 0, 8);
    check_slot(2, 8'h92, 1'b1, 0, 4);
    en = 1'b0;
    data = 16'hA5C7;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_out($sformatf("disabled %0d", k), 8'hFF, 4'hF, 1'b0);
    end

    // Frame 5: restart from digit 0 with a fresh snapshot.
    en = 1'b1;
    step();
    check_slot(0, 8'h8F, 1'b1, 0, 8);
    check_slot(1, 8'hB1, 1'b1, 0, 8);
    check_slot(2, 8'hA4, 1'b1, 0, 8);
    check_slot(3, 8'h88, 1'b1, 0, 8);

    // Frame 6: reset during SHOW of digit 3.
    check_slot(0, 8'h8F, 1'b1, 0, 8);
    check_slot(1, 8'hB1, 1'b1, 0, 8);
    check_slot(2, 8'hA4, 1'b1, 0, 8);
    check_slot(3, 8'h88, 1'b1, 0, 4);
    rst_n = 1'b0;
    step();
    chk_out("midreset 0", 8'hFF, 4'hF, 1'b0);
    step();
    chk_out("midreset 1", 8'hFF, 4'hF, 1'b0);

    // Frame 7: scanning resumes at digit 0.
    rst_n = 1'b1;
    step();
    check_slot(0, 8'h8F, 1'b1, 0, 8);
    check_slot(1, 8'hB1, 1'b1, 0, 8);
    check_slot(2, 8'hA4, 1'b1, 0, 8);
    check_slot(3, 8'h88, 1'b1, 0, 8);
    chk_out("next frame", 8'hFF, 4'hF, 1'b1);

    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
